// File: rtl/pixel_compositor.sv
// Three-stage pixel compositor: map/character address generation, RAM data alignment,
// and transparency-aware selection between the character sprite and the scrolled map.
module pixel_compositor #(
  parameter int         MAP_W      = 1152,
  parameter int         MAP_H      = 1024,
  parameter int         SPR_W      = 16,
  parameter int         SPR_H      = 24,
  parameter logic [4:0] TRANSP_IDX = 5'd0,
  parameter logic [4:0] BORDER_IDX = 5'd0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_in_valid,
  input  logic        frame_start,
  input  logic [10:0] cam_x,
  input  logic [10:0] cam_y,
  input  logic [9:0]  char_x,
  input  logic [9:0]  char_y,
  input  logic [1:0]  char_frame,
  output logic [20:0] map_read_address,
  output logic [12:0] char_read_address,
  input  logic [4:0]  map_data,
  input  logic [4:0]  char_data,
  output logic [4:0]  palette_idx,
  output logic        pix_out_valid
);

  localparam logic [11:0] MAP_W_L   = 12'(MAP_W);
  localparam logic [11:0] MAP_H_L   = 12'(MAP_H);
  localparam logic [10:0] SPR_W_L   = 11'(SPR_W);
  localparam logic [10:0] SPR_H_L   = 11'(SPR_H);
  localparam logic [12:0] FRAME_SZ  = 13'(SPR_W * SPR_H);

  typedef struct packed {
    logic [10:0] cam_x;
    logic [10:0] cam_y;
    logic [9:0]  char_x;
    logic [9:0]  char_y;
    logic [1:0]  frame;
  } shadow_t;

  shadow_t shadow;

  // Scene parameters are sampled once per frame so a mid-frame change cannot tear the image.
  // NOTE: sequential state is always written with non-blocking assignments so every
  // register samples pre-edge values; this is also what gives a pixel coincident with
  // frame_start the old shadow contents.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow <= '0;
    end else if (frame_start) begin
      shadow <= '{cam_x: cam_x, cam_y: cam_y, char_x: char_x,
                  char_y: char_y, frame: char_frame};
    end
  end

  // ---------------- Stage A: address generation ----------------
  logic [11:0] map_x, map_y;
  logic        off_map;
  logic [20:0] map_addr_next;
  logic [10:0] pix_x, pix_y, spr_x, spr_y;
  logic        char_hit;
  logic [9:0]  rel_x, rel_y;
  logic [12:0] char_addr_next;

  // NOTE: every always_comb output gets a default before any branch so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    map_x          = {2'b00, DrawX} + {1'b0, shadow.cam_x};
    map_y          = {2'b00, DrawY} + {1'b0, shadow.cam_y};
    off_map        = (map_x >= MAP_W_L) || (map_y >= MAP_H_L);
    map_addr_next  = '0;
    if (!off_map) begin
      map_addr_next = 21'(map_y) * 21'(MAP_W) + 21'(map_x);
    end

    // 11-bit compares keep char_x+SPR_W from wrapping back onto column 0.
    pix_x    = {1'b0, DrawX};
    pix_y    = {1'b0, DrawY};
    spr_x    = {1'b0, shadow.char_x};
    spr_y    = {1'b0, shadow.char_y};
    char_hit = (pix_x >= spr_x) && (pix_x < spr_x + SPR_W_L) &&
               (pix_y >= spr_y) && (pix_y < spr_y + SPR_H_L);
    rel_x          = DrawX - shadow.char_x;
    rel_y          = DrawY - shadow.char_y;
    char_addr_next = '0;
    if (char_hit) begin
      char_addr_next = 13'(shadow.frame) * FRAME_SZ
                     + 13'(rel_y) * 13'(SPR_W) + 13'(rel_x);
    end
  end

  logic off_a, hit_a, valid_a;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      map_read_address  <= '0;
      char_read_address <= '0;
      off_a             <= 1'b0;
      hit_a             <= 1'b0;
      valid_a           <= 1'b0;
    end else begin
      map_read_address  <= map_addr_next;
      char_read_address <= char_addr_next;
      off_a             <= off_map;
      hit_a             <= char_hit;
      valid_a           <= pix_in_valid;
    end
  end

  // ---------------- Stage B: wait for RAM read data ----------------
  logic off_b, hit_b, valid_b;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      off_b   <= 1'b0;
      hit_b   <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      off_b   <= off_a;
      hit_b   <= hit_a;
      valid_b <= valid_a;
    end
  end

  // ---------------- Stage C: composite ----------------
  logic [4:0] pix_sel;

  always_comb begin
    pix_sel = '0;
    if (valid_b) begin
      if (hit_b && (char_data != TRANSP_IDX)) pix_sel = char_data;
      else if (off_b)                          pix_sel = BORDER_IDX;
      else                                     pix_sel = map_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      palette_idx   <= '0;
      pix_out_valid <= 1'b0;
    end else begin
      palette_idx   <= pix_sel;
      pix_out_valid <= valid_b;
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: directed scenarios plus randomized pixels,
// compared against a per-pixel compositing model driven by the scene rules.
module tb_pixel_compositor;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        pix_in_valid, frame_start;
  logic [10:0] cam_x, cam_y;
  logic [9:0]  char_x, char_y;
  logic [1:0]  char_frame;
  logic [20:0] map_read_address;
  logic [12:0] char_read_address;
  logic [4:0]  map_data = '0, char_data = '0;
  logic [4:0]  palette_idx;
  logic        pix_out_valid;

  pixel_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_in_valid(pix_in_valid), .frame_start(frame_start),
    .cam_x(cam_x), .cam_y(cam_y), .char_x(char_x), .char_y(char_y),
    .char_frame(char_frame), .map_read_address(map_read_address),
    .char_read_address(char_read_address), .map_data(map_data),
    .char_data(char_data), .palette_idx(palette_idx),
    .pix_out_valid(pix_out_valid)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read RAM models: data follows the address by one clock.
  logic [4:0] char_mem [0:8191];

  function automatic logic [4:0] map_fn(input logic [20:0] a);
    return 5'(a ^ (a >> 5) ^ (a >> 11));
  endfunction

  always @(posedge Clk) begin
    map_data  <= map_fn(map_read_address);
    char_data <= char_mem[char_read_address];
  end

  typedef struct {
    int         maddr;
    int         caddr;
    logic       v;
    logic [4:0] pal;
  } exp_t;

  exp_t ring [64];
  int   cyc;
  int   n_cmp;
  int   n_fail;
  bit   in_rst;
  int   s_cx, s_cy, s_chx, s_chy, s_fr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    e = ring[(cyc - 1) % 64];
    check("map_addr", 32'(map_read_address), 32'(e.maddr));
    check("char_addr", 32'(char_read_address), 32'(e.caddr));
    if (cyc >= 3) begin
      e = ring[(cyc - 3) % 64];
      check("out_valid", 32'(pix_out_valid), 32'(e.v));
      check("palette", 32'(palette_idx), 32'(e.pal));
    end
  endtask

  // Drive one pixel for one cycle and record what the compositor must produce for it.
  task automatic pix(input int x, input int y, input bit v, input bit fs);
    exp_t e;
    int   mx, my;
    bit   off, hit;
    logic [4:0] cd;
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    pix_in_valid = v;
    frame_start  = fs;
    e = '{maddr: 0, caddr: 0, v: 1'b0, pal: 5'd0};
    if (!in_rst) begin
      mx  = x + s_cx;
      my  = y + s_cy;
      off = (mx >= 1152) || (my >= 1024);
      e.maddr = off ? 0 : my * 1152 + mx;
      hit = (x >= s_chx) && (x < s_chx + 16) && (y >= s_chy) && (y < s_chy + 24);
      e.caddr = hit ? s_fr * 384 + (y - s_chy) * 16 + (x - s_chx) : 0;
      cd  = char_mem[e.caddr];
      e.v = v;
      if (v) e.pal = (hit && cd != 5'd0) ? cd : off ? 5'd0 : map_fn(21'(e.maddr));
      if (fs) begin
        s_cx = int'(cam_x); s_cy = int'(cam_y);
        s_chx = int'(char_x); s_chy = int'(char_y); s_fr = int'(char_frame);
      end
    end
    ring[cyc % 64] = e;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) pix(0, 0, 1'b0, 1'b0);
  endtask

  task automatic scene(input int cx, input int cy, input int hx, input int hy, input int fr);
    cam_x = 11'(cx); cam_y = 11'(cy);
    char_x = 10'(hx); char_y = 10'(hy); char_frame = 2'(fr);
  endtask

  // Asynchronous reset mid-stream: everything in flight is lost, shadows return to 0.
  task automatic reset_pulse(input int n);
    Reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(pix_out_valid), 32'd0);
    check("rst_palette", 32'(palette_idx), 32'd0);
    check("rst_map_addr", 32'(map_read_address), 32'd0);
    ring[(cyc - 1) % 64] = '{maddr: 0, caddr: 0, v: 1'b0, pal: 5'd0};
    ring[(cyc - 2) % 64] = '{maddr: 0, caddr: 0, v: 1'b0, pal: 5'd0};
    s_cx = 0; s_cy = 0; s_chx = 0; s_chy = 0; s_fr = 0;
    in_rst = 1'b1;
    repeat (n) pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1, 1'b0);
    in_rst  = 1'b0;
    Reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; in_rst = 1'b0;
    s_cx = 0; s_cy = 0; s_chx = 0; s_chy = 0; s_fr = 0;
    for (int i = 0; i < 8192; i++) char_mem[i] = 5'($urandom);
    for (int i = 0; i < 64; i++) ring[i] = '{maddr: 0, caddr: 0, v: 1'b0, pal: 5'd0};
    Reset_n = 1'b0;
    DrawX = '0; DrawY = '0; pix_in_valid = 1'b0; frame_start = 1'b0;
    scene(0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_valid", 32'(pix_out_valid), 32'd0);
    check("reset_palette", 32'(palette_idx), 32'd0);
    check("reset_map_addr", 32'(map_read_address), 32'd0);
    check("reset_char_addr", 32'(char_read_address), 32'd0);
    Reset_n = 1'b1;

    // Shadows stay 0 until the first frame_start, whatever the scene inputs say.
    scene(200, 300, 4, 4, 2);
    pix(7, 3, 1'b1, 1'b0);
    check("pre_fs_addr", 32'(map_read_address), 32'(3 * 1152 + 7));
    idle(3);

    // Basic map fetch with no character overlap.
    scene(0, 0, 900, 900, 0);
    pix(0, 0, 1'b0, 1'b1);
    pix(5, 2, 1'b1, 1'b0);
    check("basic_map_addr", 32'(map_read_address), 32'd2309);
    idle(2);
    check("basic_valid", 32'(pix_out_valid), 32'd1);
    idle(1);

    // Opaque character pixel, then the same pixel made transparent.
    scene(0, 0, 100, 50, 1);
    pix(0, 0, 1'b0, 1'b1);
    char_mem[419] = 5'd9;
    pix(103, 52, 1'b1, 1'b0);
    check("char_addr_hit", 32'(char_read_address), 32'd419);
    idle(2);
    check("char_opaque", 32'(palette_idx), 32'd9);
    idle(1);
    char_mem[419] = 5'd0;
    pix(103, 52, 1'b1, 1'b0);
    idle(2);
    check("char_transp", 32'(palette_idx), 32'(map_fn(21'(52 * 1152 + 103))));
    idle(1);

    // Camera pushes the pixel past the right map edge.
    scene(1140, 0, 900, 900, 0);
    pix(0, 0, 1'b0, 1'b1);
    pix(20, 0, 1'b1, 1'b0);
    check("offmap_addr", 32'(map_read_address), 32'd0);
    idle(2);
    check("offmap_border", 32'(palette_idx), 32'd0);
    idle(1);

    // Camera changes only take effect through frame_start; coincident pixel uses old value.
    scene(0, 10, 900, 900, 0);
    pix(0, 0, 1'b0, 1'b1);
    pix(1, 1, 1'b1, 1'b0);
    check("cam_old", 32'(map_read_address), 32'(11 * 1152 + 1));
    cam_y = 11'd20;
    pix(1, 1, 1'b1, 1'b0);
    check("cam_no_fs", 32'(map_read_address), 32'(11 * 1152 + 1));
    pix(1, 1, 1'b1, 1'b1);
    check("cam_coincident", 32'(map_read_address), 32'(11 * 1152 + 1));
    pix(1, 1, 1'b1, 1'b0);
    check("cam_new", 32'(map_read_address), 32'(21 * 1152 + 1));
    idle(3);

    // Character hanging off the right screen edge must not wrap to column 0.
    scene(0, 0, 630, 100, 0);
    char_mem[9] = 5'd13;
    pix(0, 0, 1'b0, 1'b1);
    pix(639, 100, 1'b1, 1'b0);
    check("edge_hit_addr", 32'(char_read_address), 32'd9);
    pix(0, 100, 1'b1, 1'b0);
    check("edge_nowrap_addr", 32'(char_read_address), 32'd0);
    idle(1);
    check("edge_hit_pal", 32'(palette_idx), 32'd13);
    idle(2);

    // Full scanline with a reset in the middle.
    scene(37, 400, 290, 0, 3);
    pix(0, 0, 1'b0, 1'b1);
    for (int x = 0; x < 640; x++) begin
      if (x == 300) reset_pulse(2);
      pix(x, 5, 1'b1, 1'b0);
    end
    idle(3);

    // Randomized traffic: scene inputs wander every cycle, shadows move only on frame_start.
    for (int i = 0; i < 2000; i++) begin
      scene(int'($urandom_range(0, 1300)), int'($urandom_range(0, 1100)),
            int'($urandom_range(0, 650)), int'($urandom_range(0, 490)),
            int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        char_x = 10'(int'(DrawX) - int'($urandom_range(0, 15)));
        char_y = 10'(int'(DrawY) - int'($urandom_range(0, 23)));
      end
      pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 24) == 0));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
